// File: rtl/rr_mux_pkg.sv
// Shared types and constants for the 4-requester round-robin mux arbiter.
package rr_mux_pkg;
    localparam int N_REQ = 4;
    localparam int SEL_W = 2;

    typedef logic [SEL_W-1:0] sel_t;
    typedef logic [N_REQ-1:0] req_vec_t;

    localparam sel_t PTR_RST = 2'd3;
endpackage

// File: rtl/rr_pick_4.sv
// Combinational round-robin picker: first set request scanning last+1 .. last (mod 4).
module rr_pick_4
    import rr_mux_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] last,
    output logic             any_grant,
    output logic [SEL_W-1:0] grant,
    output logic [N_REQ-1:0] grant_onehot
);
    sel_t idx;

    // The pointer itself is scanned last, so a lone requester is never blocked.
    always_comb begin
        any_grant    = 1'b0;
        grant        = last;
        grant_onehot = '0;
        idx          = last;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = last + sel_t'(i);
            if (!any_grant && req[idx]) begin
                any_grant = 1'b1;
                grant     = idx;
            end
        end
        if (any_grant) begin
            grant_onehot[grant] = 1'b1;
        end
    end
endmodule

// File: rtl/rr_mux_4_arb.sv
// Round-robin 4:1 mux with a single-entry registered output stage.
// Optional burst locking is enabled by defining RR_MUX_BURST_LOCK_EN.
module rr_mux_4_arb
    import rr_mux_pkg::*;
#(
    parameter int WIDTH = 4
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] in_valid,
`ifdef RR_MUX_BURST_LOCK_EN
    input  logic [N_REQ-1:0] in_last,
`endif
    output logic [N_REQ-1:0] in_ready,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [SEL_W-1:0] out_sel
);
    logic             full_q, full_d;
    logic [WIDTH-1:0] data_q, data_d;
    sel_t             sel_q, sel_d;
    sel_t             last_q, last_d;

    logic [WIDTH-1:0] lane [N_REQ];
    req_vec_t         eligible;
    req_vec_t         grant_onehot;
    sel_t             grant;
    logic             any_grant;
    logic             load_en;
    logic             active;

    assign lane[0] = d0;
    assign lane[1] = d1;
    assign lane[2] = d2;
    assign lane[3] = d3;

`ifdef RR_MUX_BURST_LOCK_EN
    logic lock_q, lock_d;

    // While locked only the owner of the current burst may be granted.
    assign eligible = lock_q ? (in_valid & (req_vec_t'(1) << last_q)) : in_valid;
`else
    assign eligible = in_valid;
`endif

    rr_pick_4 u_pick (
        .req          (eligible),
        .last         (last_q),
        .any_grant    (any_grant),
        .grant        (grant),
        .grant_onehot (grant_onehot)
    );

    // out_ready passes straight through so a drain and a refill share one cycle.
    assign load_en  = !full_q || out_ready;
    assign active   = load_en && any_grant;
    assign in_ready = (active && rst_n) ? grant_onehot : '0;

    always_comb begin
        full_d = full_q;
        data_d = data_q;
        sel_d  = sel_q;
        last_d = last_q;
`ifdef RR_MUX_BURST_LOCK_EN
        lock_d = lock_q;
`endif
        if (active) begin
            full_d = 1'b1;
            data_d = lane[grant];
            sel_d  = grant;
            last_d = grant;
`ifdef RR_MUX_BURST_LOCK_EN
            lock_d = !in_last[grant];
`endif
        end else if (out_ready) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            data_q <= '0;
            sel_q  <= '0;
            last_q <= PTR_RST;
`ifdef RR_MUX_BURST_LOCK_EN
            lock_q <= 1'b0;
`endif
        end else begin
            full_q <= full_d;
            data_q <= data_d;
            sel_q  <= sel_d;
            last_q <= last_d;
`ifdef RR_MUX_BURST_LOCK_EN
            lock_q <= lock_d;
`endif
        end
    end

    assign out_valid = full_q;
    assign out_data  = data_q;
    assign out_sel   = sel_q;
endmodule

// File: tb/tb_rr_mux_4_arb.sv
// Directed self-checking bench for rr_mux_4_arb (also covers RR_MUX_BURST_LOCK_EN builds).
module tb_rr_mux_4_arb;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] in_valid;
    logic [3:0] in_ready;
    logic [3:0] in_last;
    logic [3:0] d0, d1, d2, d3;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;
    logic [1:0] out_sel;

    int vectors     = 0;
    int miscompares = 0;

    logic [3:0] lane_val [4] = '{4'hA, 4'hB, 4'hC, 4'hD};

    always #5 clk = ~clk;

    rr_mux_4_arb #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
`ifdef RR_MUX_BURST_LOCK_EN
        .in_last   (in_last),
`endif
        .in_ready  (in_ready),
        .d0        (d0),
        .d1        (d1),
        .d2        (d2),
        .d3        (d3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sel   (out_sel)
    );

    // Reset gating of in_ready, then 5 idle cycles with cleared outputs.
    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 4'b1111;
        in_last   = 4'b1111;
        out_ready = 1'b1;
        d0 = lane_val[0]; d1 = lane_val[1]; d2 = lane_val[2]; d3 = lane_val[3];
        #12;
        vectors++;
        if (in_ready !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL reset_in_ready_gated: got %b expected 0000", in_ready);
        end
        in_valid = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            vectors++;
            if (out_valid !== 1'b0 || in_ready !== 4'b0000 || out_data !== 4'h0 || out_sel !== 2'd0) begin
                miscompares++;
                $display("[TB] FAIL reset_idle cycle %0d: got valid=%b ready=%b data=%h sel=%0d expected 0 0000 0 0",
                         c, out_valid, in_ready, out_data, out_sel);
            end
        end
    endtask

    // All four valid: grants rotate 0,1,2,3 and data follows one cycle later.
    task automatic test_rotation();
        logic [1:0] exp_idx;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            exp_idx = 2'(k % 4);
            #1;
            vectors++;
            if (in_ready !== (4'b0001 << exp_idx)) begin
                miscompares++;
                $display("[TB] FAIL rotation_in_ready beat %0d: got %b expected %b", k, in_ready, 4'b0001 << exp_idx);
            end
            @(posedge clk); #1;
            vectors++;
            if (out_valid !== 1'b1 || out_sel !== exp_idx || out_data !== lane_val[exp_idx]) begin
                miscompares++;
                $display("[TB] FAIL rotation_out beat %0d: got valid=%b sel=%0d data=%h expected 1 %0d %h",
                         k, out_valid, out_sel, out_data, exp_idx, lane_val[exp_idx]);
            end
        end
    endtask

    // A lone requester is granted every cycle.
    task automatic test_single();
        in_valid = 4'b0100;
        d2       = 4'h5;
        for (int k = 0; k < 4; k++) begin
            #1;
            vectors++;
            if (in_ready !== 4'b0100) begin
                miscompares++;
                $display("[TB] FAIL single_in_ready beat %0d: got %b expected 0100", k, in_ready);
            end
            @(posedge clk); #1;
            vectors++;
            if (out_valid !== 1'b1 || out_sel !== 2'd2 || out_data !== 4'h5) begin
                miscompares++;
                $display("[TB] FAIL single_out beat %0d: got valid=%b sel=%0d data=%h expected 1 2 5",
                         k, out_valid, out_sel, out_data);
            end
        end
        d2 = lane_val[2];
    endtask

    // Stall with a full register, then drain and refill in the same cycle.
    task automatic test_backpressure();
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 4'b1000) begin
            miscompares++;
            $display("[TB] FAIL bp_prefill_ready: got %b expected 1000", in_ready);
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            vectors++;
            if (in_ready !== 4'b0000) begin
                miscompares++;
                $display("[TB] FAIL bp_stall_ready cycle %0d: got %b expected 0000", k, in_ready);
            end
            @(posedge clk); #1;
            vectors++;
            if (out_valid !== 1'b1 || out_sel !== 2'd3 || out_data !== 4'hD) begin
                miscompares++;
                $display("[TB] FAIL bp_hold cycle %0d: got valid=%b sel=%0d data=%h expected 1 3 d",
                         k, out_valid, out_sel, out_data);
            end
        end
        out_ready = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 4'b0001) begin
            miscompares++;
            $display("[TB] FAIL bp_release_ready: got %b expected 0001", in_ready);
        end
        @(posedge clk); #1;
        vectors++;
        if (out_valid !== 1'b1 || out_sel !== 2'd0 || out_data !== 4'hA) begin
            miscompares++;
            $display("[TB] FAIL bp_refill: got valid=%b sel=%0d data=%h expected 1 0 a", out_valid, out_sel, out_data);
        end
        in_valid = 4'b0000;
        @(posedge clk); #1;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL bp_drain_empty: got valid=%b expected 0", out_valid);
        end
    endtask

    // Asynchronous reset mid-stream discards the beat and restores priority to requester 0.
    task automatic test_async_reset();
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 4'b0000 || out_data !== 4'h0 || out_sel !== 2'd0) begin
            miscompares++;
            $display("[TB] FAIL async_reset: got valid=%b ready=%b data=%h sel=%0d expected 0 0000 0 0",
                     out_valid, in_ready, out_data, out_sel);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 4'b0001) begin
            miscompares++;
            $display("[TB] FAIL async_first_ready: got %b expected 0001", in_ready);
        end
        @(posedge clk); #1;
        vectors++;
        if (out_valid !== 1'b1 || out_sel !== 2'd0 || out_data !== 4'hA) begin
            miscompares++;
            $display("[TB] FAIL async_first_grant: got valid=%b sel=%0d data=%h expected 1 0 a", out_valid, out_sel, out_data);
        end
    endtask

    // in_last[1] low for three of its beats: locked builds hold requester 1, others rotate.
    task automatic test_burst();
        logic [1:0] exp_seq [6];
`ifdef RR_MUX_BURST_LOCK_EN
        exp_seq = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2};
`else
        exp_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
`endif
        rst_n = 1'b0;
        #3;
        @(negedge clk);
        rst_n     = 1'b1;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            in_last = (k < 4) ? 4'b1101 : 4'b1111;
            #1;
            vectors++;
            if (in_ready !== (4'b0001 << exp_seq[k])) begin
                miscompares++;
                $display("[TB] FAIL burst_in_ready beat %0d: got %b expected %b", k, in_ready, 4'b0001 << exp_seq[k]);
            end
            @(posedge clk); #1;
            vectors++;
            if (out_sel !== exp_seq[k] || out_data !== lane_val[exp_seq[k]]) begin
                miscompares++;
                $display("[TB] FAIL burst_out beat %0d: got sel=%0d data=%h expected %0d %h",
                         k, out_sel, out_data, exp_seq[k], lane_val[exp_seq[k]]);
            end
        end
        in_valid = 4'b0000;
        in_last  = 4'b1111;
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_single();
        test_backpressure();
        test_async_reset();
        test_burst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/rr_mux_4_arb.md
Name: rr_mux_4_arb

Overview:
- Round-robin arbiter and sequencer for a 4:1 data mux. Four requesters each present data with a valid/ready handshake.
- The block picks one requester per cycle, steers its data through an indexed 4:1 select, and registers the result into a single-entry output stage with valid/ready.
- It sits in front of any shared downstream consumer of 4 sources.

Parameters:
- WIDTH, 4, data width of every input lane and of out_data.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  4  bit k: requester k has data.
- in_ready  output  4  bit k: requester k's data is taken this cycle; at most one bit set (onehot or zero).
- d0, d1, d2, d3  input  WIDTH each  requester data lanes.
- out_valid  output  1  output register holds a beat.
- out_ready  input  1  consumer accepts the beat.
- out_data  output  WIDTH  registered selected data.
- out_sel  output  2  index of the requester that produced out_data.
- in_last  input  4  end-of-burst marker per requester; present only when RR_MUX_BURST_LOCK_EN is defined.

Behaviour:
- Single-entry output register: full flag, data reg, sel reg.
- load_en = !full | out_ready. This is a combinational pass-through of out_ready, so a drain and a refill happen in the same cycle.
- Arbitration is active when load_en and any in_valid is set. The grant is the first valid requester scanning last+1, last+2, last+3, last (mod 4). Here "last" is the 2-bit pointer of the previous grant.
- in_ready = onehot(grant) when arbitration is active, else 0. It is combinational from in_valid, full, out_ready and the pointer.
- in_ready never depends on its own requester's valid in a way that creates a loop. Requesters must not make in_valid depend on in_ready.
- On a grant at a clock edge:
  - out_data <= d[grant], using the indexed select over an internal 4-entry array.
  - out_sel <= grant, full <= 1, last <= grant.
- No grant and out_ready=1: full <= 0. No grant and out_ready=0: hold.
- out_valid = full.
- Latency: input handshake to out_valid is 1 cycle.
- Throughput: 1 beat/cycle while out_ready=1 and a requester is valid.
- Fairness: with all 4 continuously valid, grants follow 0,1,2,3,0,… with no requester starved more than 3 grants.
- Single requester continuously valid: granted every cycle. The pointer does not block a repeat grant.
- Backpressure: out_ready=0 with full=1 gives in_ready=0 and holds out_data, out_sel and the pointer stable.
- out_data and out_sel are stable while out_valid=1 and out_ready=0.
- Reset (asynchronous, any time, including mid-stream):
  - full=0, out_valid=0, out_data=0, out_sel=0.
  - Pointer = 3, so requester 0 has top priority after reset.
  - in_ready=0 while rst_n=0.
  - An in-flight beat in the output register is discarded.
- Width rules: pointer arithmetic is 2-bit modulo-4 wrap (3+1=0). No data transformation on any path.

Optional Feature:
- Macro: RR_MUX_BURST_LOCK_EN.
- Defined: in_last port exists. After granting requester k with in_last[k]=0, a lock flag is set and only k is eligible; all other in_ready stay 0 even if k is idle.
- The lock clears on the cycle k's beat is accepted with in_last[k]=1. Round-robin then resumes from k+1.
- Reset clears the lock.
- Undefined: no in_last port, no lock; every grant is independent.

Decomposition:
- Package rr_mux_pkg:
  - localparam N_REQ=4, SEL_W=2.
  - typedef logic [SEL_W-1:0] sel_t.
  - typedef logic [N_REQ-1:0] req_vec_t.
  - Reset pointer constant PTR_RST = 2'd3.
- Sub-module rr_pick_4: purely combinational.
  - Inputs: req_vec_t req, sel_t last.
  - Outputs: any_grant, sel_t grant, req_vec_t grant_onehot.
- Top module holds the pointer, output register, lock, indexed data array and handshake logic.

Test Plan:
- Reset release, no in_valid → out_valid=0, in_ready=0000, out_data=0, out_sel=0 for 5 cycles.
- in_valid=1111, d0..d3=A,B,C,D, out_ready=1 for 8 cycles → in_ready 0001,0010,0100,1000 repeating; one cycle later out_sel 0,1,2,3,0,… and out_data A,B,C,D,A,…
- Only in_valid[2]=1, d2=5, out_ready=1 → in_ready=0100 every cycle; out_data=5, out_sel=2 continuous.
- Full register, out_ready=0 for 4 cycles, in_valid=1111 → in_ready=0000 and out_data/out_sel frozen. Raise out_ready → the drain and the next grant occur in the same cycle, with the next grant being pointer+1.
- rst_n pulled low mid-stream with out_valid=1 → out_valid=0 immediately (asynchronous). After release with in_valid=1111, the first grant is requester 0.
- With RR_MUX_BURST_LOCK_EN, in_valid=1111, in_last[1] low for 3 beats then high → requester 1 granted 4 consecutive beats, then requester 2. Without the macro, the same stimulus gives grants rotating 0,1,2,3.
